// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if -- fetch-side and backing-memory signals of the instruction cache.
//
// Build option: ICACHE_STATS_EN adds the hit_count/miss_count statistics signals.
//
// Signals:
//   pc, req, inv        fetch request: byte address, request strobe, invalidate-all pulse
//   instruction, hit    fetch response: instruction word and its valid/stall flag
//   mem_addr, mem_rd    refill read request towards backing memory
//   mem_data, mem_valid refill read response from backing memory
//   hit_count, miss_count (ICACHE_STATS_EN only) saturating statistics counters
//
// Modports: slave = the cache controller, master = the fetch stage / memory side.
interface icache_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] pc;
  logic              req;
  logic              inv;
  logic [15:0]       instruction;
  logic              hit;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_data;
  logic              mem_valid;
`ifdef ICACHE_STATS_EN
  logic [15:0]       hit_count;
  logic [15:0]       miss_count;
`endif

  modport slave (
    input  pc, req, inv, mem_data, mem_valid,
`ifdef ICACHE_STATS_EN
    output hit_count, miss_count,
`endif
    output instruction, hit, mem_addr, mem_rd
  );

  modport master (
    output pc, req, inv, mem_data, mem_valid,
`ifdef ICACHE_STATS_EN
    input  hit_count, miss_count,
`endif
    input  instruction, hit, mem_addr, mem_rd
  );
endinterface

// File: rtl/icache_ctrl.sv
// icache_ctrl -- direct-mapped instruction cache with in-order line refill.
//
// Lookup is combinational: hit = ~req | (valid & tag match) while idle, and
// the pipeline uses hit as its enable. A miss latches the line address and
// fetches WORDS_PER_LINE words in order through a mem_rd/mem_valid handshake.
//
// Build option: define ICACHE_STATS_EN to add hit_count/miss_count outputs.
//
// Ports:
//   clk  pipeline clock
//   rst  asynchronous reset, active-high
//   bus  icache_ctrl_if.slave (pc/req/inv in, instruction/hit out,
//        mem_addr/mem_rd out, mem_data/mem_valid in, optional stats out)
module icache_ctrl #(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 16
) (
  input  logic          clk,
  input  logic          rst,
  icache_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t            state_r;
  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  miss_tag_r;
  logic [IDX_W-1:0]  miss_idx_r;
  logic [OFF_W-1:0]  cnt_r;
  logic              inv_seen_r;
  logic              mem_rd_r;
  logic [ADDR_W-1:0] mem_addr_r;

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [15:0]       data_mem [LINES][WORDS_PER_LINE];

  logic [OFF_W-1:0]  pc_off_s;
  logic [IDX_W-1:0]  pc_idx_s;
  logic [TAG_W-1:0]  pc_tag_s;
  logic [OFF_W-1:0]  cnt_inc_s;
  logic              lookup_s;
  logic              hit_s;
  logic              miss_s;
  logic              fill_s;
  logic              last_s;
  logic [15:0]       instr_s;
  logic [LINES-1:0]  valid_next_s;

  assign pc_off_s  = bus.pc[OFF_W:1];
  assign pc_idx_s  = bus.pc[OFF_W+IDX_W:OFF_W+1];
  assign pc_tag_s  = bus.pc[ADDR_W-1:OFF_W+IDX_W+1];
  assign cnt_inc_s = cnt_r + {{(OFF_W-1){1'b0}}, 1'b1};

  // Lookup, hit/stall generation and refill strobes.
  always_comb begin
    lookup_s = valid_r[pc_idx_s] && (tag_mem[pc_idx_s] == pc_tag_s);
    fill_s   = (state_r == REFILL) && bus.mem_valid;
    last_s   = (cnt_r == OFF_W'(WORDS_PER_LINE - 1));
    if (state_r == IDLE) begin
      hit_s  = ~bus.req | lookup_s;
      miss_s = bus.req & ~lookup_s;
      if (bus.req && lookup_s) begin
        instr_s = data_mem[pc_idx_s][pc_off_s];
      end else begin
        instr_s = 16'h0000;
      end
    end else begin
      hit_s   = 1'b0;
      miss_s  = 1'b0;
      instr_s = 16'h0000;
    end
  end

  // Next valid bits: inv clears everything and also vetoes the line being
  // completed, whether inv arrives now or arrived earlier in the refill.
  always_comb begin
    if (bus.inv) begin
      valid_next_s = '0;
    end else begin
      valid_next_s = valid_r;
    end
    if (fill_s && last_s && !inv_seen_r && !bus.inv) begin
      valid_next_s[miss_idx_r] = 1'b1;
    end else begin
      valid_next_s = valid_next_s;
    end
  end

  // Refill FSM with registered memory request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      valid_r    <= '0;
      miss_tag_r <= '0;
      miss_idx_r <= '0;
      cnt_r      <= '0;
      inv_seen_r <= 1'b0;
      mem_rd_r   <= 1'b0;
      mem_addr_r <= '0;
    end else begin
      valid_r <= valid_next_s;
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            state_r    <= REFILL;
            miss_tag_r <= pc_tag_s;
            miss_idx_r <= pc_idx_s;
            cnt_r      <= '0;
            inv_seen_r <= 1'b0;
            mem_rd_r   <= 1'b1;
            mem_addr_r <= {pc_tag_s, pc_idx_s, {OFF_W{1'b0}}, 1'b0};
          end
        end
        REFILL: begin
          if (bus.inv) begin
            inv_seen_r <= 1'b1;
          end
          if (bus.mem_valid) begin
            cnt_r <= cnt_inc_s;
            if (last_s) begin
              state_r  <= IDLE;
              mem_rd_r <= 1'b0;
            end else begin
              mem_addr_r <= {miss_tag_r, miss_idx_r, cnt_inc_s, 1'b0};
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          mem_rd_r <= 1'b0;
        end
      endcase
    end
  end

  // Array writes: one data word per accepted beat, tag on the final beat.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_mem[miss_idx_r][cnt_r] <= bus.mem_data;
      if (last_s) begin
        tag_mem[miss_idx_r] <= miss_tag_r;
      end
    end
  end

  assign bus.hit         = hit_s;
  assign bus.instruction = instr_s;
  assign bus.mem_rd      = mem_rd_r;
  assign bus.mem_addr    = mem_addr_r;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_r;
  logic [15:0] miss_count_r;

  // Saturating hit/miss statistics; inv restarts both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_r  <= 16'h0000;
      miss_count_r <= 16'h0000;
    end else if (bus.inv) begin
      hit_count_r  <= 16'h0000;
      miss_count_r <= 16'h0000;
    end else begin
      if ((state_r == IDLE) && bus.req && hit_s && (hit_count_r != 16'hFFFF)) begin
        hit_count_r <= hit_count_r + 16'h0001;
      end
      if (miss_s && (miss_count_r != 16'hFFFF)) begin
        miss_count_r <= miss_count_r + 16'h0001;
      end
    end
  end

  assign bus.hit_count  = hit_count_r;
  assign bus.miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl -- directed stimulus with a line-level reference model of
// the cache and a latency-programmable backing memory.
module tb_icache_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_ctrl_if #(.ADDR_W(16)) bus ();

  icache_ctrl #(.LINES(8), .WORDS_PER_LINE(4), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int lat_target  = 2;
  int lat_cnt     = 0;

  // Reference model: which line holds which block, plus the pending refill.
  bit          m_valid [8];
  int          m_tag   [8];
  bit          m_busy;
  logic [15:0] m_base;
  int          m_got;
  bit          m_inv;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic bit present(input logic [15:0] a);
    int idx;
    idx = (int'(a) / 8) % 8;
    return m_valid[idx] && (m_tag[idx] == int'(a) / 64);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then memory response, then model step.
  always @(negedge clk) begin
    bit          eh;
    logic [15:0] ei;
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_busy        = 1'b0;
      m_got         = 0;
      m_inv         = 1'b0;
      lat_cnt       = 0;
      bus.mem_valid = 1'b0;
      bus.mem_data  = 16'h0000;
    end else begin
      eh = !m_busy && (!bus.req || present(bus.pc));
      ei = (!m_busy && bus.req && present(bus.pc)) ? mem_word({bus.pc[15:1], 1'b0}) : 16'h0000;
      chk("hit", {31'd0, bus.hit}, {31'd0, eh});
      chk("instruction", {16'd0, bus.instruction}, {16'd0, ei});
      chk("mem_rd", {31'd0, bus.mem_rd}, {31'd0, m_busy});
      if (m_busy) chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, m_base + 16'(2 * m_got)});

      if (bus.mem_rd) begin
        lat_cnt++;
        if (lat_cnt >= lat_target) begin
          bus.mem_valid = 1'b1;
          bus.mem_data  = mem_word(bus.mem_addr);
          lat_cnt       = 0;
        end else begin
          bus.mem_valid = 1'b0;
        end
      end else begin
        bus.mem_valid = 1'b0;
        lat_cnt       = 0;
      end

      if (bus.inv) begin
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        if (m_busy) m_inv = 1'b1;
      end
      if (m_busy) begin
        if (bus.mem_valid) begin
          m_got++;
          if (m_got == 4) begin
            m_busy = 1'b0;
            if (!m_inv && !bus.inv) begin
              m_valid[(int'(m_base) / 8) % 8] = 1'b1;
              m_tag[(int'(m_base) / 8) % 8]   = int'(m_base) / 64;
            end
          end
        end
      end else if (bus.req && !eh) begin
        m_busy = 1'b1;
        m_base = bus.pc & 16'hFFF8;
        m_got  = 0;
        m_inv  = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hit(input string name);
    int n = 0;
    while (!bus.hit && n < 100) begin
      cyc();
      n++;
    end
    chk(name, {31'd0, bus.hit}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.mem_rd && n < 100) begin
      cyc();
      n++;
    end
    chk(name, {31'd0, bus.mem_rd}, 32'd0);
  endtask

  logic [15:0] exp_addr [8];
  logic [15:0] seq_word [4];

  initial begin
    exp_addr = '{16'h0000, 16'h0000, 16'h0002, 16'h0002,
                 16'h0004, 16'h0004, 16'h0006, 16'h0006};
    seq_word = '{16'h5A5A, 16'h5A5C, 16'h5A56, 16'h5A48};
    bus.pc = 16'h0000; bus.req = 1'b0; bus.inv = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_data = 16'h0000;
    rst = 1'b1;

    // Reset state: idle lookups report hit only when nothing is requested.
    repeat (2) cyc();
    chk("rst_hit_noreq", {31'd0, bus.hit}, 32'd1);
    chk("rst_instr", {16'd0, bus.instruction}, 32'd0);
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    bus.req = 1'b1;
    #1;
    chk("rst_hit_req", {31'd0, bus.hit}, 32'd0);

    // Cold miss at 0x0000, two-cycle memory latency.
    lat_target = 2;
    rst = 1'b0;
    #1;
    chk("cold_miss_hit", {31'd0, bus.hit}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("cold_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
      chk("cold_mem_addr", {16'd0, bus.mem_addr}, {16'd0, exp_addr[i]});
    end
    cyc();
    chk("cold_hit_c9", {31'd0, bus.hit}, 32'd1);
    chk("cold_instr", {16'd0, bus.instruction}, {16'd0, seq_word[0]});

    // Sequential hits across the freshly filled line.
    for (int k = 1; k < 4; k++) begin
      cyc();
      bus.pc = 16'(2 * k);
      #1;
      chk("seq_hit", {31'd0, bus.hit}, 32'd1);
      chk("seq_instr", {16'd0, bus.instruction}, {16'd0, seq_word[k]});
      chk("seq_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    end
    cyc();
    bus.req = 1'b0;
`ifdef ICACHE_STATS_EN
    #1;
    chk("stats_hits", {16'd0, bus.hit_count}, 32'd4);
    chk("stats_misses", {16'd0, bus.miss_count}, 32'd1);
`endif

    // Invalidate while idle: counters clear, the filled line is gone.
    bus.inv = 1'b1;
    cyc();
    bus.inv = 1'b0;
`ifdef ICACHE_STATS_EN
    #1;
    chk("stats_hits_inv", {16'd0, bus.hit_count}, 32'd0);
    chk("stats_misses_inv", {16'd0, bus.miss_count}, 32'd0);
`endif
    bus.pc = 16'h0000; bus.req = 1'b1;
    #1;
    chk("inv_idle_miss", {31'd0, bus.hit}, 32'd0);
    lat_target = 1;
    wait_hit("refill_0000");

    // Conflict eviction: 0x0040 shares index 0 with 0x0000.
    bus.pc = 16'h0040;
    #1;
    chk("conflict_miss", {31'd0, bus.hit}, 32'd0);
    wait_hit("refill_0040");
    chk("conflict_instr", {16'd0, bus.instruction}, 32'h5A9A);
    bus.pc = 16'h0000;
    #1;
    chk("evicted_miss", {31'd0, bus.hit}, 32'd0);
    wait_hit("refill_0000_again");

    // Invalidate during word 1 of a three-cycle-latency refill.
    lat_target = 3;
    bus.pc = 16'h0010;
    #1;
    chk("inv_refill_start", {31'd0, bus.hit}, 32'd0);
    repeat (5) cyc();
    chk("inv_refill_word1", {16'd0, bus.mem_addr}, 32'h0012);
    bus.inv = 1'b1;
    cyc();
    bus.inv = 1'b0;
    wait_idle("inv_refill_done");
    chk("inv_refill_miss", {31'd0, bus.hit}, 32'd0);
    wait_hit("refill_0010");
    chk("refill_0010_instr", {16'd0, bus.instruction}, 32'h5A6A);

    // Asynchronous reset in the middle of a refill.
    lat_target = 2;
    bus.pc = 16'h0020;
    #1;
    chk("rst_refill_miss", {31'd0, bus.hit}, 32'd0);
    repeat (3) cyc();
    chk("rst_refill_busy", {31'd0, bus.mem_rd}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("async_rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    cyc();
    rst = 1'b0;
    bus.pc = 16'h0000;
    #1;
    chk("post_rst_miss", {31'd0, bus.hit}, 32'd0);
    wait_hit("post_rst_refill");
    chk("post_rst_instr", {16'd0, bus.instruction}, 32'h5A5A);

    bus.req = 1'b0;
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache with refill controller. Sits directly upstream of the fetch stage: supplies the 16-bit instruction for the current PC, plus the `hit` signal.
- The fetch stage and every pipeline register use `hit` as their enable. On a miss the controller stalls the core and refills one line from backing instruction memory through a request/valid handshake.

Parameters:
- LINES, 8, number of cache lines (power of 2); index = pc[5:3] at defaults.
- WORDS_PER_LINE, 4, 16-bit words per line (power of 2); word offset = pc[2:1] at defaults.
- ADDR_W, 16, PC/byte-address width; tag = pc[ADDR_W-1:6] at defaults.

Ports:
- clk  in  1  pipeline clock (the divided clock)
- rst  in  1  asynchronous reset, active-high
- pc  in  16  byte address of the requested instruction; bit 0 is ignored
- req  in  1  fetch request
- inv  in  1  invalidate all lines (single-cycle pulse)
- instruction  out  16  instruction at pc; valid when hit=1
- hit  out  1  instruction valid this cycle; 0 stalls the pipeline
- mem_addr  out  16  word address to backing memory (byte address, bit 0 = 0)
- mem_rd  out  1  read request to backing memory
- mem_data  in  16  read data from backing memory
- mem_valid  in  1  mem_data valid; completes the current mem_rd

Behaviour:
- Reset (async, rst=1): state=IDLE; all valid bits=0; mem_rd=0; mem_addr=0; refill counter=0. Outputs during reset: hit=1 when req=0, else 0; instruction=0. Tag and data arrays are not reset.
- States: IDLE, REFILL.
- IDLE:
  - hit = ~req | (valid[idx] & tag[idx]==pc_tag), combinational.
  - instruction = data[idx][off] when hit & req, else 16'h0000.
  - A miss (req=1 & lookup fails) latches miss_tag and miss_idx, clears cnt to 0, and moves to REFILL on the next edge.
- REFILL:
  - hit=0 and instruction=0 throughout.
  - mem_rd=1 and mem_addr={miss_tag, miss_idx, cnt, 1'b0}; both are registered and held stable until mem_valid=1 is sampled.
  - On each edge with mem_valid=1: data[miss_idx][cnt]<=mem_data, then cnt<=cnt+1.
  - On the last word (cnt==WORDS_PER_LINE-1): write tag[miss_idx]<=miss_tag, set valid[miss_idx]<=1, drive mem_rd<=0, return to IDLE. The lookup is re-evaluated combinationally in the next cycle.
  - Words are fetched in order 0..WORDS_PER_LINE-1; there is no critical-word-first.
  - mem_rd deasserts for exactly one cycle between refills. It stays asserted between words of the same line.
- Miss penalty: with memory latency L cycles per word, hit returns 1 exactly 1 + WORDS_PER_LINE*L cycles after the miss cycle.
- pc changes during REFILL are ignored; the refill always completes for the latched line. The new pc is looked up in IDLE, so a second miss is possible.
- inv:
  - In IDLE: all valid bits are cleared on the edge, and lookup misses from the next cycle.
  - In REFILL: all valid bits are cleared, but the refill still runs to completion. The refilled line is NOT marked valid (inv wins), and the state returns to IDLE.
  - inv coinciding with the last mem_valid: the line is left invalid.
- rst mid-REFILL: aborts immediately; mem_rd=0 asynchronously; all lines are invalid.
- mem_valid while in IDLE is ignored.
- Index/offset/tag widths are derived with $clog2 from the parameters. The tag width is ADDR_W - log2(LINES) - log2(WORDS_PER_LINE) - 1.

Optional Feature:
- ICACHE_STATS_EN, when defined, adds two outputs: hit_count[15:0] and miss_count[15:0].
  - hit_count increments on each cycle in IDLE with req & hit.
  - miss_count increments once per IDLE-to-REFILL transition.
  - Both saturate at 16'hFFFF, reset to 0 on rst, and clear on inv.
- When the macro is undefined, these ports and their counters do not exist. Functional behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, req=1, pc=16'h0000, memory latency L=2.
  - Expect hit=0 immediately.
  - mem_addr sequence 0x0000, 0x0002, 0x0004, 0x0006, each held for 2 cycles.
  - hit=1 at cycle 9 with instruction = the word at 0x0000.
- Sequential hits: after the cold-miss refill, step pc 0x0002, 0x0004, 0x0006 one per cycle → hit=1 every cycle, instruction matches memory, mem_rd stays 0.
- Conflict eviction:
  - Fill pc=0x0000, then request pc=0x0040 (same index 0, tag 1) → miss and refill.
  - Then pc=0x0000 → miss again (line evicted).
- inv during refill:
  - Miss at 0x0010 with L=3; pulse inv during word 1.
  - Expect all 4 words still fetched and return to IDLE.
  - Then pc=0x0010 → miss again.
- Async reset mid-refill: assert rst between clock edges during REFILL → mem_rd drops to 0 without waiting for an edge. After release, pc=0x0000 misses.
- Stats (ICACHE_STATS_EN defined): cold miss plus 3 sequential hits → miss_count=1, hit_count=4 (the 4 hits are the post-refill hit on 0x0000 plus 0x0002, 0x0004, 0x0006). After inv → both counters 0.
